// File: rtl/grasshopper_pkg.sv
// Shared types, tables and GF(2^8) helpers for the Kuznyechik round engine.
// The inverse table is only referenced when GRASS_DECRYPT_EN is defined.
package grasshopper_pkg;

    localparam int BLK_W = 128;
    localparam int KEY_W = 128;
    localparam int NRND  = 10;
    localparam logic [7:0] GF_POLY = 8'hC3;

    typedef enum logic [2:0] {IDLE, XS, LIN, FIN, DONE} state_e;

    typedef logic [7:0] sbox_t [256];
    typedef logic [255:0][7:0] sbox_inv_t;

    localparam sbox_t PI = '{
        8'hFC, 8'hEE, 8'hDD, 8'h11, 8'hCF, 8'h6E, 8'h31, 8'h16, 8'hFB, 8'hC4, 8'hFA, 8'hDA, 8'h23, 8'hC5, 8'h04, 8'h4D,
        8'hE9, 8'h77, 8'hF0, 8'hDB, 8'h93, 8'h2E, 8'h99, 8'hBA, 8'h17, 8'h36, 8'hF1, 8'hBB, 8'h14, 8'hCD, 8'h5F, 8'hC1,
        8'hF9, 8'h18, 8'h65, 8'h5A, 8'hE2, 8'h5C, 8'hEF, 8'h21, 8'h81, 8'h1C, 8'h3C, 8'h42, 8'h8B, 8'h01, 8'h8E, 8'h4F,
        8'h05, 8'h84, 8'h02, 8'hAE, 8'hE3, 8'h6A, 8'h8F, 8'hA0, 8'h06, 8'h0B, 8'hED, 8'h98, 8'h7F, 8'hD4, 8'hD3, 8'h1F,
        8'hEB, 8'h34, 8'h2C, 8'h51, 8'hEA, 8'hC8, 8'h48, 8'hAB, 8'hF2, 8'h2A, 8'h68, 8'hA2, 8'hFD, 8'h3A, 8'hCE, 8'hCC,
        8'hB5, 8'h70, 8'h0E, 8'h56, 8'h08, 8'h0C, 8'h76, 8'h12, 8'hBF, 8'h72, 8'h13, 8'h47, 8'h9C, 8'hB7, 8'h5D, 8'h87,
        8'h15, 8'hA1, 8'h96, 8'h29, 8'h10, 8'h7B, 8'h9A, 8'hC7, 8'hF3, 8'h91, 8'h78, 8'h6F, 8'h9D, 8'h9E, 8'hB2, 8'hB1,
        8'h32, 8'h75, 8'h19, 8'h3D, 8'hFF, 8'h35, 8'h8A, 8'h7E, 8'h6D, 8'h54, 8'hC6, 8'h80, 8'hC3, 8'hBD, 8'h0D, 8'h57,
        8'hDF, 8'hF5, 8'h24, 8'hA9, 8'h3E, 8'hA8, 8'h43, 8'hC9, 8'hD7, 8'h79, 8'hD6, 8'hF6, 8'h7C, 8'h22, 8'hB9, 8'h03,
        8'hE0, 8'h0F, 8'hEC, 8'hDE, 8'h7A, 8'h94, 8'hB0, 8'hBC, 8'hDC, 8'hE8, 8'h28, 8'h50, 8'h4E, 8'h33, 8'h0A, 8'h4A,
        8'hA7, 8'h97, 8'h60, 8'h73, 8'h1E, 8'h00, 8'h62, 8'h44, 8'h1A, 8'hB8, 8'h38, 8'h82, 8'h64, 8'h9F, 8'h26, 8'h41,
        8'hAD, 8'h45, 8'h46, 8'h92, 8'h27, 8'h5E, 8'h55, 8'h2F, 8'h8C, 8'hA3, 8'hA5, 8'h7D, 8'h69, 8'hD5, 8'h95, 8'h3B,
        8'h07, 8'h58, 8'hB3, 8'h40, 8'h86, 8'hAC, 8'h1D, 8'hF7, 8'h30, 8'h37, 8'h6B, 8'hE4, 8'h88, 8'hD9, 8'hE7, 8'h89,
        8'hE1, 8'h1B, 8'h83, 8'h49, 8'h4C, 8'h3F, 8'hF8, 8'hFE, 8'h8D, 8'h53, 8'hAA, 8'h90, 8'hCA, 8'hD8, 8'h85, 8'h61,
        8'h20, 8'h71, 8'h67, 8'hA4, 8'h2D, 8'h2B, 8'h09, 8'h5B, 8'hCB, 8'h9B, 8'h25, 8'hD0, 8'hBE, 8'hE5, 8'h6C, 8'h52,
        8'h59, 8'hA6, 8'h74, 8'hD2, 8'hE6, 8'hF4, 8'hB4, 8'hC0, 8'hD1, 8'h66, 8'hAF, 8'hC2, 8'h39, 8'h4B, 8'h63, 8'hB6
    };

    // Coefficient j multiplies byte a(15-j), i.e. the first entry applies to a15.
    localparam logic [7:0] LCOEF [16] = '{
        8'd148, 8'd32, 8'd133, 8'd16, 8'd194, 8'd192, 8'd1, 8'd251,
        8'd1, 8'd192, 8'd194, 8'd16, 8'd133, 8'd32, 8'd148, 8'd1
    };

    function automatic sbox_inv_t pi_inv_gen();
        sbox_inv_t t;
        t = '0;
        for (int i = 0; i < 256; i++) t[PI[i]] = 8'(i);
        return t;
    endfunction

    localparam sbox_inv_t PI_INV = pi_inv_gen();

    function automatic logic [7:0] gf_mul8(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ GF_POLY) : {x[6:0], 1'b0};
        end
        return p;
    endfunction

    function automatic logic [7:0] l_func(input logic [BLK_W-1:0] x);
        logic [7:0] acc;
        acc = '0;
        for (int j = 0; j < 16; j++) acc = acc ^ gf_mul8(LCOEF[j], x[BLK_W-1-8*j -: 8]);
        return acc;
    endfunction

    function automatic logic [BLK_W-1:0] s_fwd(input logic [BLK_W-1:0] x);
        logic [BLK_W-1:0] y;
        for (int b = 0; b < 16; b++) y[8*b +: 8] = PI[x[8*b +: 8]];
        return y;
    endfunction

    function automatic logic [BLK_W-1:0] s_inv(input logic [BLK_W-1:0] x);
        logic [BLK_W-1:0] y;
        for (int b = 0; b < 16; b++) y[8*b +: 8] = PI_INV[x[8*b +: 8]];
        return y;
    endfunction

endpackage

// File: rtl/grasshopper_lstep.sv
// Combinational slice of the linear layer: LSTEP chained R steps (dir=0)
// or R^-1 steps (dir=1) on one 128-bit block.
module grasshopper_lstep
    import grasshopper_pkg::*;
#(
    parameter int LSTEP = 4
) (
    input  logic             dir,
    input  logic [BLK_W-1:0] din,
    output logic [BLK_W-1:0] dout
);

    function automatic logic [BLK_W-1:0] r_fwd(input logic [BLK_W-1:0] x);
        return {l_func(x), x[BLK_W-1:8]};
    endfunction

    // R^-1 rotates a15 to the bottom so l() sees (a14..a0, a15) and rebuilds a0.
    function automatic logic [BLK_W-1:0] r_inv(input logic [BLK_W-1:0] x);
        return {x[BLK_W-9:0], l_func({x[BLK_W-9:0], x[BLK_W-1 -: 8]})};
    endfunction

    logic [BLK_W-1:0] chain [LSTEP+1];

    assign chain[0] = din;

    for (genvar i = 0; i < LSTEP; i++) begin : g_step
        assign chain[i+1] = dir ? r_inv(chain[i]) : r_fwd(chain[i]);
    end

    assign dout = chain[LSTEP];

endmodule

// File: rtl/grasshopper_round_engine.sv
// Iterative Kuznyechik block engine: one X/S stage plus a serialised L layer reused for all rounds.
// Optional decryption is enabled by defining GRASS_DECRYPT_EN (adds the decrypt_i port).
module grasshopper_round_engine
    import grasshopper_pkg::*;
#(
    parameter int LSTEP   = 4,
    parameter int NROUNDS = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [BLK_W-1:0]      data_i,
    input  logic [NRND*KEY_W-1:0] rkeys_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [BLK_W-1:0]      data_o,
    output logic                  busy_o
`ifdef GRASS_DECRYPT_EN
    ,
    input  logic                  decrypt_i
`endif
);

    if (!(LSTEP == 1 || LSTEP == 2 || LSTEP == 4 || LSTEP == 8 || LSTEP == 16)) begin : g_bad_lstep
        $error("grasshopper_round_engine: LSTEP must be 1, 2, 4, 8 or 16");
    end
    if (NROUNDS != NRND) begin : g_bad_nrounds
        $error("grasshopper_round_engine: NROUNDS must be 10");
    end

    localparam logic [3:0] STEP_LAST = 4'(16 / LSTEP - 1);
    localparam logic [3:0] RND_LAST  = 4'(NROUNDS - 2);

    state_e           state_q, state_d;
    logic [3:0]       rnd_q, rnd_d;
    logic [3:0]       step_q, step_d;
    logic             ready_q, ready_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic [BLK_W-1:0] dout_q, dout_d;
    logic [BLK_W-1:0] st_q, st_d;
    logic [BLK_W-1:0] lin_out;
    logic [BLK_W-1:0] inv_st;
    logic [BLK_W-1:0] rkey;
    logic [3:0]       kidx;
    logic             accept;
    logic             dec_q;

`ifdef GRASS_DECRYPT_EN
    logic dec_d;
    assign dec_d  = accept ? decrypt_i : dec_q;
    assign inv_st = s_inv(st_q);
`else
    assign dec_q  = 1'b0;
    assign inv_st = st_q;
`endif

    assign accept = valid_i && ready_q;

    // Encrypt walks K1..K10 upward; decrypt starts at K10 and finishes with K1 in FIN.
    always_comb begin
        kidx = rnd_q;
        if (state_q == FIN) kidx = dec_q ? 4'd0 : 4'd9;
        else if (dec_q)     kidx = 4'd9 - rnd_q;
    end

    assign rkey = rkeys_i[{kidx, 7'd0} +: KEY_W];

    grasshopper_lstep #(.LSTEP(LSTEP)) u_lstep (
        .dir  (dec_q),
        .din  (st_q),
        .dout (lin_out)
    );

    always_comb begin
        state_d = state_q;
        rnd_d   = rnd_q;
        step_d  = step_q;
        st_d    = st_q;
        dout_d  = dout_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    st_d    = data_i;
                    rnd_d   = '0;
                    state_d = XS;
                end
            end
            XS: begin
                if (dec_q) st_d = ((rnd_q == 4'd0) ? st_q : inv_st) ^ rkey;
                else       st_d = s_fwd(st_q ^ rkey);
                step_d  = '0;
                state_d = LIN;
            end
            LIN: begin
                st_d   = lin_out;
                step_d = step_q + 4'd1;
                if (step_q == STEP_LAST) begin
                    step_d  = '0;
                    rnd_d   = rnd_q + 4'd1;
                    state_d = (rnd_q == RND_LAST) ? FIN : XS;
                end
            end
            FIN: begin
                dout_d  = (dec_q ? inv_st : st_q) ^ rkey;
                state_d = DONE;
            end
            DONE: begin
                if (ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
        valid_d = (state_d == DONE);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            rnd_q   <= '0;
            step_q  <= '0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            dout_q  <= '0;
`ifdef GRASS_DECRYPT_EN
            dec_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            step_q  <= step_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            dout_q  <= dout_d;
`ifdef GRASS_DECRYPT_EN
            dec_q   <= dec_d;
`endif
        end
    end

    // The working block carries no reset: it is always reloaded on accept.
    always_ff @(posedge clk) begin
        st_q <= st_d;
    end

    assign ready_o = ready_q;
    assign valid_o = valid_q;
    assign busy_o  = busy_q;
    assign data_o  = dout_q;

endmodule
